// File: rtl/fpu_io_pkg.sv
// Shared definitions for the FP calculator's off-chip I/O blocks
// (operand receiver and result transmitter).
package fpu_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        RELEASE
    } tx_state_e;

    localparam int FP_RESULT_W = 10;
    localparam int FP_BEAT_W   = 10;

    // io pin positions: ack comes in on io_in, valid ("done") goes out on io_out
    localparam int ACK_PIN   = 0;
    localparam int VALID_PIN = 10;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input,
// asynchronously reset to 0.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fpu_result_tx.sv
// Result transmitter: buffers finished calculator results and sends them
// off-chip MS beat first over a 4-phase valid/ack handshake.
module fpu_result_tx
    import fpu_io_pkg::*;
#(
    parameter int DATA_W = FP_RESULT_W,
    parameter int BEAT_W = FP_BEAT_W,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] result,
    input  logic              done_calc,
    input  logic              host_ack,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              overflow,
    output logic              busy
);

    localparam int NBEATS = DATA_W / BEAT_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BIDX_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(NBEATS - 1);

    function automatic logic [BEAT_W-1:0] beat_of(input logic [DATA_W-1:0] word,
                                                   input logic [BIDX_W-1:0] idx);
        logic [DATA_W-1:0] shifted;
        shifted = word << (int'(idx) * BEAT_W);
        return shifted[DATA_W-1 -: BEAT_W];
    endfunction

    logic ack_s;

    sync_2ff u_ack_sync (
        .clock (clock),
        .reset (reset),
        .d     (host_ack),
        .q     (ack_s)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    tx_state_e         state;
    logic [BIDX_W-1:0] beat_idx;
    logic [BIDX_W-1:0] next_idx;
    logic              last_beat;
    logic              pop;
    logic              push;

    assign next_idx  = beat_idx + 1'b1;
    assign last_beat = (beat_idx == LAST_BEAT);
    assign pop       = (state == RELEASE) && !ack_s && last_beat;
    assign push      = done_calc && ((count != FULL_CNT) || pop);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= result;
    end

    // The head entry stays in the buffer for the whole handshake, so a
    // non-IDLE state always implies a non-zero count: busy reduces to count!=0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            busy  <= (count_nxt != '0);
            if (done_calc && !push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beat_idx  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        out_data  <= beat_of(mem[rd_ptr], beat_idx);
                        out_valid <= 1'b1;
                        out_last  <= last_beat;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack_s) begin
                        out_valid <= 1'b0;
                        state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait for ack to drop so a stuck-high ack cannot advance twice
                    if (!ack_s) begin
                        if (last_beat) begin
                            beat_idx <= '0;
                            out_last <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            beat_idx  <= next_idx;
                            out_data  <= beat_of(mem[rd_ptr], next_idx);
                            out_valid <= 1'b1;
                            out_last  <= (next_idx == LAST_BEAT);
                            state     <= PRESENT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_result_tx.sv
// Self-checking bench for fpu_result_tx: table-driven single results,
// directed corner sequences, and a randomized run against a queue model.
module tb_fpu_result_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  result = '0;
    logic        done_calc = 1'b0;
    logic        host_ack = 1'b0;
    logic [9:0]  out_data;
    logic        out_valid, out_last, overflow, busy;

    logic [19:0] result2 = '0;
    logic        done2 = 1'b0;
    logic        ack2 = 1'b0;
    logic [9:0]  out_data2;
    logic        out_valid2, out_last2, overflow2, busy2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    fpu_result_tx #(.DATA_W(10), .BEAT_W(10), .DEPTH(2)) dut (
        .clock(clock), .reset(reset), .result(result), .done_calc(done_calc),
        .host_ack(host_ack), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .overflow(overflow), .busy(busy)
    );

    fpu_result_tx #(.DATA_W(20), .BEAT_W(10), .DEPTH(2)) dut2 (
        .clock(clock), .reset(reset), .result(result2), .done_calc(done2),
        .host_ack(ack2), .out_data(out_data2), .out_valid(out_valid2),
        .out_last(out_last2), .overflow(overflow2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input logic lvl, input string name);
        int n;
        n = 0;
        while (out_valid !== lvl && n < 200) begin
            tick();
            n++;
        end
        if (out_valid !== lvl)
            check(name, {31'd0, out_valid}, {31'd0, lvl});
    endtask

    task automatic host_beat(input int dly, output logic [9:0] d, output logic l);
        wait_valid(1'b1, "host_wait_valid_hi");
        d = out_data;
        l = out_last;
        tick(dly);
        host_ack = 1'b1;
        wait_valid(1'b0, "host_wait_valid_lo");
        host_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        done_calc = 1'b0;
        host_ack  = 1'b0;
        tick(2);
        reset = 1'b0;
        tick();
    endtask

    // Randomized-phase reference model: queue of accepted results plus occupancy
    logic       gen_on = 1'b0;
    logic       auto_on = 1'b0;
    logic [9:0] exp_q[$];
    int         mcount = 0;
    int         pop_cd = 0;
    int         hs = 0;
    int         hdly = 0;
    int         hwait = 0;
    logic       exp_ovf = 1'b0;
    logic       pop_now;

    always @(negedge clock) begin
        if (auto_on) begin
            // A released final beat leaves the buffer on the third edge after ack drops
            pop_now = 1'b0;
            if (pop_cd > 0) begin
                pop_cd--;
                pop_now = (pop_cd == 0);
            end
            if (done_calc) begin
                if (mcount < 2 || pop_now) begin
                    exp_q.push_back(result);
                    mcount++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            if (pop_now)
                mcount--;
            check("rnd_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
            check("rnd_busy", {31'd0, busy}, {31'd0, mcount != 0});

            case (hs)
                0: if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rnd_spurious: got %0h, expected no transfer", out_data);
                    end else begin
                        check("rnd_data", {22'd0, out_data}, {22'd0, exp_q.pop_front()});
                    end
                    check("rnd_last", {31'd0, out_last}, 32'd1);
                    hdly = $urandom_range(0, 4);
                    hs = 1;
                end
                1: if (hdly == 0) begin
                    host_ack = 1'b1;
                    hwait = 0;
                    hs = 2;
                end else begin
                    hdly--;
                end
                2: if (!out_valid) begin
                    host_ack = 1'b0;
                    pop_cd = 3;
                    hs = 0;
                end else if (++hwait > 50) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rnd_valid_stuck: got 1, expected 0");
                    host_ack = 1'b0;
                    hs = 0;
                end
                default: hs = 0;
            endcase

            done_calc = gen_on && ($urandom_range(0, 3) == 0);
            result    = 10'($urandom);
        end
    end

    typedef struct {
        logic [9:0] res;
        int         dly;
        logic [9:0] exp_data;
        logic       exp_last;
    } vec_t;

    vec_t tbl[4];
    logic [9:0] d;
    logic       l;

    initial begin
        tbl[0] = '{10'h2A5, 3, 10'h2A5, 1'b1};
        tbl[1] = '{10'h000, 0, 10'h000, 1'b1};
        tbl[2] = '{10'h3FF, 5, 10'h3FF, 1'b1};
        tbl[3] = '{10'h155, 1, 10'h155, 1'b1};

        tick(2);
        check("rst_out_data", {22'd0, out_data}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            result = tbl[i].res;
            done_calc = 1'b1;
            tick();
            done_calc = 1'b0;
            result = '0;
            check("t_busy_capture", {31'd0, busy}, 32'd1);
            check("t_valid_early", {31'd0, out_valid}, 32'd0);
            tick();
            check("t_valid", {31'd0, out_valid}, 32'd1);
            check("t_data", {22'd0, out_data}, {22'd0, tbl[i].exp_data});
            check("t_last", {31'd0, out_last}, {31'd0, tbl[i].exp_last});
            tick(tbl[i].dly);
            host_ack = 1'b1;
            tick(2);
            check("t_valid_hold", {31'd0, out_valid}, 32'd1);
            tick();
            check("t_valid_fall", {31'd0, out_valid}, 32'd0);
            check("t_data_stable", {22'd0, out_data}, {22'd0, tbl[i].exp_data});
            host_ack = 1'b0;
            tick(3);
            check("t_busy_done", {31'd0, busy}, 32'd0);
            check("t_last_clear", {31'd0, out_last}, 32'd0);
        end

        // Back-to-back results, slow host
        result = 10'h001;
        done_calc = 1'b1;
        tick();
        result = 10'h3FF;
        tick();
        done_calc = 1'b0;
        host_beat(20, d, l);
        check("b2b_first", {22'd0, d}, 32'h001);
        tick(3);
        check("b2b_no_early_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("b2b_revalid", {31'd0, out_valid}, 32'd1);
        host_beat(20, d, l);
        check("b2b_second", {22'd0, d}, 32'h3FF);
        check("b2b_last", {31'd0, l}, 32'd1);
        check("b2b_overflow", {31'd0, overflow}, 32'd0);
        tick(3);
        check("b2b_idle", {31'd0, busy}, 32'd0);

        // Overflow: third result while full is dropped
        result = 10'h011;
        done_calc = 1'b1;
        tick();
        result = 10'h022;
        tick();
        check("ovf_not_yet", {31'd0, overflow}, 32'd0);
        result = 10'h033;
        tick();
        done_calc = 1'b0;
        check("ovf_set", {31'd0, overflow}, 32'd1);
        host_beat(2, d, l);
        check("ovf_first", {22'd0, d}, 32'h011);
        host_beat(2, d, l);
        check("ovf_second", {22'd0, d}, 32'h022);
        tick(12);
        check("ovf_dropped", {31'd0, out_valid}, 32'd0);
        check("ovf_idle", {31'd0, busy}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        do_reset();
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Push coinciding with the final-beat release of a full buffer
        result = 10'h0A1;
        done_calc = 1'b1;
        tick();
        result = 10'h0A2;
        tick();
        done_calc = 1'b0;
        wait_valid(1'b1, "pop_wait_hi");
        check("pop_head", {22'd0, out_data}, 32'h0A1);
        host_ack = 1'b1;
        wait_valid(1'b0, "pop_wait_lo");
        host_ack = 1'b0;
        tick(2);
        result = 10'h0A3;
        done_calc = 1'b1;
        tick();
        done_calc = 1'b0;
        check("pop_no_overflow", {31'd0, overflow}, 32'd0);
        host_beat(1, d, l);
        check("pop_second", {22'd0, d}, 32'h0A2);
        host_beat(1, d, l);
        check("pop_third", {22'd0, d}, 32'h0A3);
        tick(3);
        check("pop_idle", {31'd0, busy}, 32'd0);

        // Two-beat result on the 20-bit instance
        result2 = 20'hABCDE;
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        tick();
        check("mb_valid0", {31'd0, out_valid2}, 32'd1);
        check("mb_beat0", {22'd0, out_data2}, 32'h2AF);
        check("mb_last0", {31'd0, out_last2}, 32'd0);
        ack2 = 1'b1;
        tick(3);
        check("mb_fall0", {31'd0, out_valid2}, 32'd0);
        ack2 = 1'b0;
        tick(3);
        check("mb_valid1", {31'd0, out_valid2}, 32'd1);
        check("mb_beat1", {22'd0, out_data2}, 32'h0DE);
        check("mb_last1", {31'd0, out_last2}, 32'd1);
        check("mb_busy_mid", {31'd0, busy2}, 32'd1);
        ack2 = 1'b1;
        tick(3);
        ack2 = 1'b0;
        tick(3);
        check("mb_done_busy", {31'd0, busy2}, 32'd0);
        check("mb_done_valid", {31'd0, out_valid2}, 32'd0);
        check("mb_overflow", {31'd0, overflow2}, 32'd0);

        // Reset during PRESENT with two buffered results
        result = 10'h1C3;
        done_calc = 1'b1;
        tick();
        result = 10'h1C4;
        tick();
        done_calc = 1'b0;
        check("rmid_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rmid_async_valid", {31'd0, out_valid}, 32'd0);
        check("rmid_async_busy", {31'd0, busy}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(10);
        check("rmid_quiet_valid", {31'd0, out_valid}, 32'd0);
        check("rmid_quiet_busy", {31'd0, busy}, 32'd0);
        result = 10'h0F0;
        done_calc = 1'b1;
        tick();
        done_calc = 1'b0;
        host_beat(1, d, l);
        check("rmid_new", {22'd0, d}, 32'h0F0);
        tick(3);

        // Randomized traffic against the queue model
        do_reset();
        exp_q.delete();
        mcount = 0;
        pop_cd = 0;
        hs = 0;
        exp_ovf = 1'b0;
        gen_on = 1'b1;
        auto_on = 1'b1;
        tick(2000);
        gen_on = 1'b0;
        tick(300);
        auto_on = 1'b0;
        check("rnd_drained", exp_q.size(), 32'd0);
        check("rnd_final_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_result_tx.md
Name: fpu_result_tx

Overview:
- Output-side transmitter for the chip's FP calculator.
- Captures each finished result when the datapath pulses done_calc and holds it in a 2-entry buffer.
- Drives the result off-chip over the output pins using a 4-phase valid/ack handshake with the external host.
- Counterpart of the input receiver that assembles operands and opcode from io_in; the host's ack arrives on one io_in pin.

Parameters:
- DATA_W, 10: width of one calculator result.
- BEAT_W, 10: data pins per beat. DATA_W must be an integer multiple of BEAT_W.
- NBEATS, DATA_W/BEAT_W: derived, not overridable.
- DEPTH, 2: result buffer entries. Must be a power of 2.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- result  input  DATA_W  calculator output; sampled only when done_calc=1
- done_calc  input  1  single-cycle pulse, result valid
- host_ack  input  1  raw ack from io_in pin; asynchronous to clock
- out_data  output  BEAT_W  current beat on io_out
- out_valid  output  1  beat valid (the io_out "done" pin)
- out_last  output  1  high with the final beat of a result
- overflow  output  1  sticky: a result was dropped because the buffer was full
- busy  output  1  buffer non-empty or handshake in progress

Behaviour:
- Clocking and reset:
  - Reset is reset, asynchronous, active-high; clock is clock, rising edge.
  - All outputs are registered. Reset values: out_data=0, out_valid=0, out_last=0, overflow=0, busy=0.
  - Reset also clears the FIFO pointers and count, sets state=IDLE, beat_idx=0, and clears both ack synchroniser flops.
- ack synchroniser:
  - host_ack passes through a 2-flop synchroniser; ack_s is its output.
  - The FSM uses only ack_s.
  - A host_ack edge is therefore visible to the FSM 2 edges later.
- FIFO:
  - Circular buffer, DEPTH entries, with wr_ptr/rd_ptr/count.
  - Push when done_calc=1 and (count<DEPTH or a pop occurs in the same cycle).
  - Push when full with no simultaneous pop: result dropped, overflow<=1. overflow holds until reset.
  - Pop occurs only on the final-beat release (see FSM). Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, PRESENT, RELEASE.
  - IDLE: if count>0 (registered count, i.e. excluding a push in this cycle):
    - load out_data with beat beat_idx of the head entry; beat 0 is the MS BEAT_W bits.
    - out_valid<=1; out_last<=(beat_idx==NBEATS-1); go to PRESENT.
  - PRESENT: hold out_data and out_valid. On ack_s=1: out_valid<=0, go to RELEASE. out_data stays stable.
  - RELEASE: wait for ack_s=0, then:
    - if not the last beat: beat_idx++, load the next beat, out_valid<=1, go to PRESENT.
    - if the last beat: pop, beat_idx<=0, out_last<=0, go to IDLE.
- Latency (empty FIFO, IDLE):
  - done_calc sampled high at edge E0.
  - At E1, out_valid=1 with data.
- Handshake timing:
  - Host raises ack immediately after seeing valid: out_valid falls 3 edges after host_ack rises (2 sync + 1 registered output).
  - Minimum per beat is about 6 cycles plus host latency.
- No done_calc throttling: the datapath never stalls. Loss is reported only through overflow.
- busy = (count!=0) || (state!=IDLE), registered.
- host_ack held high in IDLE: no effect. PRESENT for the next beat is entered only after the ack_s=0 seen in RELEASE, so a stuck ack cannot double-count.
- Reset mid-handshake: immediate return to IDLE with the buffer emptied. The host sees out_valid drop asynchronously.

Decomposition:
- Shared package fpu_io_pkg holds:
  - tx_state_e enum (IDLE, PRESENT, RELEASE);
  - FP_RESULT_W=10 and BEAT_W defaults, also used by the input receiver;
  - io pin index constants (ACK_PIN, VALID_PIN).
- One natural sub-module: sync_2ff, the generic 2-flop synchroniser with async reset to 0, reusable by the receiver.
- The FIFO stays inline.

Test Plan:
- Single result, defaults: done_calc pulse with result=10'h2A5, host acks 3 cycles after valid → out_data=10'h2A5 with out_valid=1 one edge after capture, out_last=1; valid falls 3 edges after ack; busy=0 after ack release.
- Back-to-back: 10'h001 and 10'h3FF on consecutive cycles, slow host (ack 20 cycles) → delivered in order 001 then 3FF; no overflow; out_valid re-asserts only after ack_s returns low.
- Overflow: 3 pulses (0x011, 0x022, 0x033) while host holds ack low → 0x011 and 0x022 delivered, 0x033 dropped, overflow=1 from the third capture edge until reset.
- Push on pop: FIFO full, third done_calc coincides with the final-beat release of the head → accepted, overflow stays 0, all 3 delivered.
- Multi-beat: DATA_W=20, BEAT_W=10, result=20'hABCDE → beat0=10'h2AF (out_last=0), then beat1=10'h0DE (out_last=1); one pop.
- Reset mid-op: assert reset while in PRESENT with 2 buffered results → out_valid=0 asynchronously, busy=0; after release, nothing transmits until a new done_calc.
